// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;
    localparam int unsigned FETCH_PC_STEP = 4;

    // One IF/ID entry as seen by decode
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// IF/ID output register backed by a one-entry skid buffer, with flush.
// skid_valid_nxt lets the fetch FSM see whether the skid fills on this edge.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               skid_valid,
    output logic               skid_valid_nxt
);

    logic               out_valid_q;
    logic               skid_valid_q;
    logic [ADDR_W-1:0]  out_pc_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic [ADDR_W-1:0]  skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic               out_free;
    logic               out_valid_nxt;

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_instr  = out_instr_q;
    assign skid_valid = skid_valid_q;

    // Output slot frees up when empty or being consumed this cycle
    assign out_free = !out_valid_q || out_ready;

    // Next valid bits: skid drains into IF/ID first, new data lands behind it
    always_comb begin
        out_valid_nxt  = out_valid_q;
        skid_valid_nxt = skid_valid_q;
        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (out_free) begin
            out_valid_nxt  = skid_valid_q || in_valid;
            skid_valid_nxt = skid_valid_q && in_valid;
        end else begin
            out_valid_nxt  = 1'b1;
            skid_valid_nxt = skid_valid_q || in_valid;
        end
    end

    // Valid bit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_nxt;
            skid_valid_q <= skid_valid_nxt;
        end
    end

    // Data registers; contents under a cleared valid are don't-care
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid_q) begin
                    out_pc_q    <= skid_pc_q;
                    out_instr_q <= skid_instr_q;
                end else if (in_valid) begin
                    out_pc_q    <= in_pc;
                    out_instr_q <= in_instr;
                end
            end
            if (in_valid && (skid_valid_q || !out_free)) begin
                skid_pc_q    <= in_pc;
                skid_instr_q <= in_instr;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives next_pc/pc_en for the external PC register,
// runs a single-outstanding req/ack fetch to imem, and hands {pc, instr} to
// decode through fetch_skid_buf. Redirects flush the stage; a pending request
// is still completed on the bus and its data thrown away (DISCARD).
// Optional: define FETCH_PERF_CNT_EN to build the stall/discard counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int PC_STEP = FETCH_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               pc_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_discard_cnt
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              in_flight;
    logic              accept;
    logic              skid_valid;
    logic              skid_valid_nxt;

    assign in_flight = (state_q == FETCH) || (state_q == WAIT);
    assign accept    = in_flight && imem_ack && !redirect_valid;

    // Bus side: address is live PC on the first request cycle, then held
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == FETCH) ? pc : addr_q;

    // PC update: redirect wins over a sequential advance
    assign pc_en   = reset && (redirect_valid || accept);
    assign next_pc = redirect_valid ? redirect_target
                                    : imem_addr + ADDR_W'(PC_STEP);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only start a new request while the skid has room
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!skid_valid) state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (redirect_valid)
                    state_d = imem_ack ? FETCH : DISCARD;
                else if (imem_ack)
                    state_d = skid_valid_nxt ? IDLE : FETCH;
                else
                    state_d = WAIT;
            end
            DISCARD: begin
                if (imem_ack) state_d = skid_valid_nxt ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold the request address for WAIT/DISCARD cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (state_q == FETCH) begin
            addr_q <= pc;
        end
    end

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk            (clk),
        .reset          (reset),
        .flush          (redirect_valid),
        .in_valid       (accept),
        .in_pc          (imem_addr),
        .in_instr       (imem_rdata),
        .out_valid      (id_valid),
        .out_ready      (id_ready),
        .out_pc         (id_pc),
        .out_instr      (id_instr),
        .skid_valid     (skid_valid),
        .skid_valid_nxt (skid_valid_nxt)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] discard_q;
    logic        stall_evt;
    logic        discard_evt;

    assign stall_evt   = imem_req && !imem_ack;
    assign discard_evt = imem_ack && ((state_q == DISCARD) || (in_flight && redirect_valid));

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q   <= '0;
            discard_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (discard_evt && (discard_q != '1))
                discard_q <= discard_q + 32'd1;
        end
    end

    assign perf_stall_cnt   = stall_q;
    assign perf_discard_cnt = discard_q;
`else
    assign perf_stall_cnt   = 32'd0;
    assign perf_discard_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: models the PC register and a simple imem
// whose data is {16'hC0DE, addr[15:0]}; ack is req gated by ack_gate.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, next_pc, redirect_target, imem_addr, imem_rdata;
    logic [31:0] id_pc, id_instr, perf_stall_cnt, perf_discard_cnt;
    logic        pc_en, redirect_valid, imem_req, imem_ack, id_valid, id_ready;
    logic        ack_gate;
    logic [31:0] rst_pc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          k;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req & ack_gate;
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    // PC register model
    always @(posedge clk or negedge reset) begin
        if (!reset)     pc <= rst_pc;
        else if (pc_en) pc <= next_pc;
    end

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .next_pc          (next_pc),
        .pc_en            (pc_en),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_pc            (id_pc),
        .id_instr         (id_instr),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_discard_cnt (perf_discard_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [31:0] p);
        reset           = 1'b0;
        rst_pc          = p;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        ack_gate        = 1'b1;
        id_ready        = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    logic [31:0] exp_stall3, exp_disc1;

    initial begin
`ifdef FETCH_PERF_CNT_EN
        exp_stall3 = 32'd3;
        exp_disc1  = 32'd1;
`else
        exp_stall3 = 32'd0;
        exp_disc1  = 32'd0;
`endif
        // 1: streaming after reset
        do_reset(32'h3000);
        #1;
        chk("t1 req at release", 32'(imem_req), 32'd0);
        chk("t1 stall cnt rst", perf_stall_cnt, 32'd0);
        chk("t1 discard cnt rst", perf_discard_cnt, 32'd0);
        tick();
        chk("t1 req c1", 32'(imem_req), 32'd1);
        chk("t1 addr c1", imem_addr, 32'h3000);
        chk("t1 pc_en c1", 32'(pc_en), 32'd1);
        chk("t1 next_pc c1", next_pc, 32'h3004);
        chk("t1 id_valid c1", 32'(id_valid), 32'd0);
        tick();
        chk("t1 addr c2", imem_addr, 32'h3004);
        chk("t1 pc_en c2", 32'(pc_en), 32'd1);
        chk("t1 id_valid c2", 32'(id_valid), 32'd1);
        chk("t1 id_pc c2", id_pc, 32'h3000);
        chk("t1 id_instr c2", id_instr, 32'hC0DE3000);
        tick();
        chk("t1 addr c3", imem_addr, 32'h3008);
        chk("t1 id_pc c3", id_pc, 32'h3004);

        // 2: ack delayed three cycles
        do_reset(32'h3000);
        ack_gate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2 addr held", imem_addr, 32'h3000);
            chk("t2 req held", 32'(imem_req), 32'd1);
            chk("t2 no pc_en", 32'(pc_en), 32'd0);
        end
        tick();
        ack_gate = 1'b1;
        #1;
        chk("t2 addr ack", imem_addr, 32'h3000);
        chk("t2 pc_en ack", 32'(pc_en), 32'd1);
        chk("t2 next_pc ack", next_pc, 32'h3004);
        tick();
        chk("t2 id_pc", id_pc, 32'h3000);
        chk("t2 addr next", imem_addr, 32'h3004);
        chk("t2 stall cnt", perf_stall_cnt, exp_stall3);

        // 3: decode backpressure fills the skid
        do_reset(32'h3000);
        id_ready = 1'b0;
        tick();
        chk("t3 id_valid c1", 32'(id_valid), 32'd0);
        tick();
        chk("t3 id_pc c2", id_pc, 32'h3000);
        chk("t3 addr c2", imem_addr, 32'h3004);
        tick();
        chk("t3 no req c3", 32'(imem_req), 32'd0);
        chk("t3 id hold c3", id_pc, 32'h3000);
        tick();
        chk("t3 no req c4", 32'(imem_req), 32'd0);
        chk("t3 id_valid c4", 32'(id_valid), 32'd1);
        tick();
        id_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (id_valid) begin
                chk("t3 delivery", id_pc, 32'h3000 + 32'(4 * k));
                k++;
            end
            tick();
        end
        chk("t3 delivery count", 32'(k >= 4), 32'd1);

        // 4: redirect while WAIT pending
        do_reset(32'h3000);
        tick();
        tick();
        tick();
        ack_gate = 1'b0;
        #1;
        chk("t4 addr c3", imem_addr, 32'h3008);
        chk("t4 pc_en c3", 32'(pc_en), 32'd0);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h4000;
        #1;
        chk("t4 req c4", 32'(imem_req), 32'd1);
        chk("t4 addr c4", imem_addr, 32'h3008);
        chk("t4 pc_en c4", 32'(pc_en), 32'd1);
        chk("t4 next_pc c4", next_pc, 32'h4000);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4 addr held c5", imem_addr, 32'h3008);
        chk("t4 req held c5", 32'(imem_req), 32'd1);
        chk("t4 id flushed c5", 32'(id_valid), 32'd0);
        tick();
        ack_gate = 1'b1;
        #1;
        chk("t4 discard no pc_en", 32'(pc_en), 32'd0);
        chk("t4 addr c6", imem_addr, 32'h3008);
        tick();
        chk("t4 addr target", imem_addr, 32'h4000);
        chk("t4 dropped data", 32'(id_valid), 32'd0);
        chk("t4 discard cnt", perf_discard_cnt, exp_disc1);
        tick();
        chk("t4 id_pc target", id_pc, 32'h4000);
        chk("t4 id_instr target", id_instr, 32'hC0DE4000);

        // 5: redirect coincident with ack, IF/ID occupied
        do_reset(32'h3000);
        tick();
        tick();
        chk("t5 id_valid c2", 32'(id_valid), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h4000;
        #1;
        chk("t5 next_pc", next_pc, 32'h4000);
        chk("t5 pc_en", 32'(pc_en), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5 id flushed", 32'(id_valid), 32'd0);
        chk("t5 addr target", imem_addr, 32'h4000);
        chk("t5 discard cnt", perf_discard_cnt, exp_disc1);
        tick();
        chk("t5 id_pc target", id_pc, 32'h4000);

        // 6: async reset mid-WAIT
        do_reset(32'h3000);
        ack_gate = 1'b0;
        tick();
        tick();
        chk("t6 req in wait", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6 req async clr", 32'(imem_req), 32'd0);
        chk("t6 id_valid clr", 32'(id_valid), 32'd0);
        chk("t6 pc_en clr", 32'(pc_en), 32'd0);
        chk("t6 stall cnt clr", perf_stall_cnt, 32'd0);
        rst_pc = 32'h5000;
        tick();
        tick();
        reset    = 1'b1;
        ack_gate = 1'b1;
        tick();
        chk("t6 restart addr", imem_addr, 32'h5000);
        chk("t6 restart req", 32'(imem_req), 32'd1);
        tick();
        chk("t6 restart id_pc", id_pc, 32'h5000);

        // 7: PC wraps at the top of the address space
        do_reset(32'hFFFF_FFFC);
        tick();
        chk("t7 addr top", imem_addr, 32'hFFFF_FFFC);
        chk("t7 next_pc wrap", next_pc, 32'h0);
        tick();
        chk("t7 addr wrapped", imem_addr, 32'h0);
        chk("t7 id_pc top", id_pc, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
